// File: rtl/la_oai21_pipe_if.sv
// Valid/ready bundle for la_oai21_pipe: producer side (operands) and consumer side (result).
// The master modport is the producer/consumer environment; the slave modport is the pipeline.
interface la_oai21_pipe_if #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 2
);
  localparam int CW = $clog2(DEPTH + 1);

  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a0;
  logic [WIDTH-1:0] a1;
  logic [WIDTH-1:0] b0;
  logic             inv;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] z;
  logic [CW-1:0]    count;

  modport master (
    output in_valid, a0, a1, b0, inv, out_ready,
    input  in_ready, out_valid, z, count
  );

  modport slave (
    input  in_valid, a0, a1, b0, inv, out_ready,
    output in_ready, out_valid, z, count
  );
endinterface

// File: rtl/la_oai21_pipe.sv
// WIDTH-bit OR-AND-(optional)INVERT evaluated at the input, with the result carried
// through a DEPTH-stage elastic valid/ready pipeline whose bubbles collapse.
module la_oai21_pipe #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 2,
  parameter     PROP  = "DEFAULT"
) (
  input  logic           clk,
  input  logic           reset,
  la_oai21_pipe_if.slave bus
);
  localparam int CW = $clog2(DEPTH + 1);

  logic [DEPTH-1:0]            r_vld;
  logic [DEPTH-1:0][WIDTH-1:0] r_dat;
  logic [CW-1:0]               r_count;

  logic [WIDTH-1:0]            w_or_and;
  logic [WIDTH-1:0]            w_fn;
  logic [DEPTH-1:0]            w_free;
  logic [DEPTH-1:0]            w_src_vld;
  logic [DEPTH-1:0][WIDTH-1:0] w_src_dat;
  logic                        w_in_xfer;
  logic                        w_out_xfer;

  // Only the function result is stored; operands are not kept past the accept.
  assign w_or_and = (bus.a0 | bus.a1) & bus.b0;
  assign w_fn     = bus.inv ? w_or_and : ~w_or_and;

  // A stage may load when it is empty or its content is moving on; the chain runs
  // back from out_ready so a full pipeline can still accept while draining.
  always_comb begin
    logic w_chain;
    w_chain = bus.out_ready;
    w_free  = '0;
    for (int i = DEPTH - 1; i >= 0; i--) begin
      w_chain   = ~r_vld[i] | w_chain;
      w_free[i] = w_chain;
    end
  end

  always_comb begin
    w_src_vld    = '0;
    w_src_dat    = '0;
    w_src_vld[0] = bus.in_valid;
    w_src_dat[0] = w_fn;
    for (int i = 1; i < DEPTH; i++) begin
      w_src_vld[i] = r_vld[i-1];
      w_src_dat[i] = r_dat[i-1];
    end
  end

  // Data only loads with a valid source, so an emptied output keeps its last z.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_vld <= '0;
      r_dat <= '0;
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        if (w_free[i]) begin
          r_vld[i] <= w_src_vld[i];
          if (w_src_vld[i]) r_dat[i] <= w_src_dat[i];
        end
      end
    end
  end

  assign w_in_xfer  = bus.in_valid & w_free[0];
  assign w_out_xfer = r_vld[DEPTH-1] & bus.out_ready;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_count <= '0;
    end else begin
      case ({w_in_xfer, w_out_xfer})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  assign bus.in_ready  = w_free[0];
  assign bus.out_valid = r_vld[DEPTH-1];
  assign bus.z         = r_dat[DEPTH-1];
  assign bus.count     = r_count;
endmodule

// File: tb/tb_la_oai21_pipe.sv
// Directed bench for la_oai21_pipe (DEPTH=3 main instance, DEPTH=1 side instance)
// with a result scoreboard filled on accept and drained on each output transfer.
module tb_la_oai21_pipe;
  localparam int W = 4;
  localparam int D = 3;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  la_oai21_pipe_if #(.WIDTH(W), .DEPTH(D)) bus ();
  la_oai21_pipe_if #(.WIDTH(W), .DEPTH(1)) bus1 ();

  la_oai21_pipe #(.WIDTH(W), .DEPTH(D), .PROP("DEFAULT")) dut (
    .clk(clk), .reset(rst), .bus(bus.slave)
  );
  la_oai21_pipe #(.WIDTH(W), .DEPTH(1), .PROP("DEFAULT")) dut1 (
    .clk(clk), .reset(rst), .bus(bus1.slave)
  );

  int npass = 0;
  int nfail = 0;
  int ntot  = 0;
  int mcnt  = 0;
  logic [W-1:0] sb[$];

  function automatic logic [W-1:0] f(input logic [W-1:0] a0, input logic [W-1:0] a1,
                                     input logic [W-1:0] b0, input logic inv);
    logic [W-1:0] t;
    t = (a0 | a1) & b0;
    return inv ? t : ~t;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    ntot++;
    assert (obs === exp) npass++;
    else begin
      nfail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic drv(input logic v, input logic [W-1:0] a0, input logic [W-1:0] a1,
                     input logic [W-1:0] b0, input logic inv);
    bus.in_valid = v;
    bus.a0 = a0;
    bus.a1 = a1;
    bus.b0 = b0;
    bus.inv = inv;
  endtask

  // One clock of the main instance: called just after a falling edge, checks the
  // occupancy model and any output transfer, then advances to the next falling edge.
  task automatic cyc();
    logic acc, pop;
    logic [W-1:0] exp;
    #1;
    acc = bus.in_valid & bus.in_ready;
    pop = bus.out_valid & bus.out_ready;
    chk("count", 32'(bus.count), 32'(mcnt));
    if (pop) begin
      chk("sb_nonempty", 32'(sb.size() != 0), 32'd1);
      if (sb.size() != 0) begin
        exp = sb.pop_front();
        chk("z_order", 32'(bus.z), 32'(exp));
      end
    end
    if (acc) sb.push_back(f(bus.a0, bus.a1, bus.b0, bus.inv));
    mcnt = mcnt + int'(acc) - int'(pop);
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic drain();
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    for (int k = 0; k < 20 && sb.size() != 0; k++) cyc();
    chk("drain_sb", 32'(sb.size()), 32'd0);
    chk("drain_ovalid", 32'(bus.out_valid), 32'd0);
    chk("drain_count", 32'(bus.count), 32'd0);
  endtask

  initial begin
    drv(1'b0, '0, '0, '0, 1'b0);
    bus.out_ready  = 1'b0;
    bus1.in_valid  = 1'b0;
    bus1.a0 = '0; bus1.a1 = '0; bus1.b0 = '0; bus1.inv = 1'b0;
    bus1.out_ready = 1'b0;

    // reset state
    #1;
    chk("rst_ovalid", 32'(bus.out_valid), 32'd0);
    chk("rst_z", 32'(bus.z), 32'd0);
    chk("rst_count", 32'(bus.count), 32'd0);
    chk("rst1_count", 32'(bus1.count), 32'd0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("rst_inready", 32'(bus.in_ready), 32'd1);
    @(negedge clk);

    // function and latency, inv=0 then inv=1
    for (int p = 0; p < 2; p++) begin
      bus.out_ready = 1'b1;
      drv(1'b1, 4'b0011, 4'b0101, 4'b1110, p[0]);
      cyc();
      drv(1'b0, '0, '0, '0, 1'b0);
      chk("lat_e1_ovalid", 32'(bus.out_valid), 32'd0);
      cyc();
      chk("lat_e2_ovalid", 32'(bus.out_valid), 32'd0);
      cyc();
      chk("lat_e3_ovalid", 32'(bus.out_valid), 32'd1);
      chk("func_z", 32'(bus.z), (p == 0) ? 32'h9 : 32'h6);
      drain();
    end

    // streaming
    bus.out_ready = 1'b1;
    for (int i = 0; i < 16; i++) begin
      drv(1'b1, W'($urandom_range(0, 15)), W'($urandom_range(0, 15)),
          W'($urandom_range(0, 15)), 1'($urandom_range(0, 1)));
      #1;
      chk("stream_inready", 32'(bus.in_ready), 32'd1);
      chk("stream_count_le3", 32'(bus.count <= 2'd3), 32'd1);
      cyc();
    end
    drain();

    // back-pressure
    bus.out_ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      drv(1'b1, W'(k + 1), 4'h8, 4'hF, 1'b1);
      #1;
      chk("bp_inready", 32'(bus.in_ready), 32'd1);
      cyc();
    end
    drv(1'b1, 4'h4, 4'h2, 4'h7, 1'b0);
    #1;
    chk("bp_full_count", 32'(bus.count), 32'd3);
    chk("bp_full_inready", 32'(bus.in_ready), 32'd0);
    chk("bp_full_z", 32'(bus.z), 32'(f(4'h1, 4'h8, 4'hF, 1'b1)));
    cyc();
    chk("bp_hold_z", 32'(bus.z), 32'(f(4'h1, 4'h8, 4'hF, 1'b1)));
    chk("bp_hold_ovalid", 32'(bus.out_valid), 32'd1);
    bus.out_ready = 1'b1;
    #1;
    chk("bp_release_inready", 32'(bus.in_ready), 32'd1);
    cyc();
    chk("bp_release_count", 32'(bus.count), 32'd3);
    drain();

    // random bubbles on both sides
    for (int i = 0; i < 1000; i++) begin
      drv(1'($urandom_range(0, 1)), W'($urandom_range(0, 15)), W'($urandom_range(0, 15)),
          W'($urandom_range(0, 15)), 1'($urandom_range(0, 1)));
      bus.out_ready = 1'($urandom_range(0, 1));
      cyc();
    end
    drain();

    // reset mid-operation
    bus.out_ready = 1'b0;
    drv(1'b1, 4'hF, 4'h0, 4'hF, 1'b1);
    cyc();
    drv(1'b1, 4'h3, 4'h0, 4'h1, 1'b1);
    cyc();
    drv(1'b0, '0, '0, '0, 1'b0);
    cyc();
    chk("mid_count", 32'(bus.count), 32'd2);
    chk("mid_ovalid", 32'(bus.out_valid), 32'd1);
    rst = 1'b1;
    #1;
    chk("arst_ovalid", 32'(bus.out_valid), 32'd0);
    chk("arst_z", 32'(bus.z), 32'd0);
    chk("arst_count", 32'(bus.count), 32'd0);
    sb.delete();
    mcnt = 0;
    @(posedge clk);
    @(negedge clk);
    chk("arst_hold_ovalid", 32'(bus.out_valid), 32'd0);
    rst = 1'b0;
    #1;
    chk("arst_inready", 32'(bus.in_ready), 32'd1);
    @(negedge clk);
    bus.out_ready = 1'b1;
    drv(1'b1, 4'h6, 4'h1, 4'h5, 1'b0);
    cyc();
    drain();

    // DEPTH=1 instance
    bus1.out_ready = 1'b0;
    bus1.in_valid  = 1'b1;
    bus1.a0 = 4'h2; bus1.a1 = 4'h0; bus1.b0 = 4'h3; bus1.inv = 1'b1;
    #1;
    chk("d1_empty_inready", 32'(bus1.in_ready), 32'd1);
    @(posedge clk);
    @(negedge clk);
    bus1.a0 = 4'h4; bus1.a1 = 4'h1; bus1.b0 = 4'hF; bus1.inv = 1'b0;
    #1;
    chk("d1_full_count", 32'(bus1.count), 32'd1);
    chk("d1_full_inready", 32'(bus1.in_ready), 32'd0);
    chk("d1_full_z", 32'(bus1.z), 32'h2);
    bus1.out_ready = 1'b1;
    #1;
    chk("d1_pass_inready", 32'(bus1.in_ready), 32'd1);
    @(posedge clk);
    @(negedge clk);
    bus1.in_valid = 1'b0;
    #1;
    chk("d1_pass_count", 32'(bus1.count), 32'd1);
    chk("d1_pass_z", 32'(bus1.z), 32'hA);
    @(posedge clk);
    @(negedge clk);
    chk("d1_empty_count", 32'(bus1.count), 32'd0);
    chk("d1_empty_ovalid", 32'(bus1.out_valid), 32'd0);

    $display("%0d/%0d checks passed", npass, ntot);
    $finish;
  end
endmodule
